// File: rtl/fx_mul_pkg.sv
// Shared constants and elaboration helpers for the fixed-point multiplier pipeline.
// Testbenches import this package so they use the same latency figure as the RTL.
package fx_mul_pkg;

    localparam logic RND_TRUNC     = 1'b0;
    localparam logic RND_HALF_AWAY = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Number of terms left after l pairwise reduction levels.
    function automatic int tree_terms(input int n, input int l);
        int c;
        c = n;
        for (int i = 0; i < l; i++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int lat_cycles(input int data_w);
        return clog2(data_w) + 4;
    endfunction

endpackage

// File: rtl/fx_mul_reduce_tree.sv
// Registered pairwise adder tree, one level per stage, with a valid/sideband
// shift register running alongside so control stays aligned with the sum.
module fx_mul_reduce_tree
    import fx_mul_pkg::*;
#(
    parameter int N_TERMS = 17,
    parameter int TERM_W  = 34,
    parameter int SIDE_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [SIDE_W-1:0]         in_side,
    input  logic [N_TERMS*TERM_W-1:0] in_terms,
    output logic                      out_valid,
    output logic [SIDE_W-1:0]         out_side,
    output logic [TERM_W-1:0]         out_sum,
    output logic                      busy
);

    localparam int LVL = clog2(N_TERMS);

    logic [LVL-1:0]    vld_d, vld_q;
    logic [SIDE_W-1:0] side_d [LVL];
    logic [SIDE_W-1:0] side_q [LVL];

    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        localparam int N_IN  = tree_terms(N_TERMS, l);
        localparam int N_OUT = tree_terms(N_TERMS, l + 1);

        logic [N_IN*TERM_W-1:0]    in_w;
        logic [2*N_OUT*TERM_W-1:0] in_pad;
        logic [N_OUT*TERM_W-1:0]   sum_d, sum_q;

        if (l == 0) begin : g_first
            assign in_w = in_terms;
        end else begin : g_next
            assign in_w = g_lvl[l-1].sum_q;
        end

        // An odd leftover term is paired with zero, so it passes through registered.
        assign in_pad = (2*N_OUT*TERM_W)'(in_w);

        always_comb begin
            sum_d = sum_q;
            if (en) begin
                for (int j = 0; j < N_OUT; j++) begin
                    sum_d[j*TERM_W +: TERM_W] = in_pad[2*j*TERM_W +: TERM_W]
                                              + in_pad[(2*j+1)*TERM_W +: TERM_W];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sum_q <= '0;
            else        sum_q <= sum_d;
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < LVL; i++) side_d[i] = side_q[i];
        if (en) begin
            vld_d[0]  = in_valid;
            side_d[0] = in_side;
            for (int i = 1; i < LVL; i++) begin
                vld_d[i]  = vld_q[i-1];
                side_d[i] = side_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LVL; i++) side_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LVL; i++) side_q[i] <= side_d[i];
        end
    end

    assign out_valid = vld_q[LVL-1];
    assign out_side  = side_q[LVL-1];
    assign out_sum   = g_lvl[LVL-1].sum_q;
    assign busy      = |vld_q;

endmodule

// File: rtl/fx_mul_pipe.sv
// Fully pipelined signed fixed-point multiplier: sign/magnitude split, shift-and-add
// tree, then rescale by 2^-FRAC_W with optional rounding and saturation.
module fx_mul_pipe
    import fx_mul_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int FRAC_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              round_mode,
    input  logic              sat_en,
    output logic              out_valid,
    output logic [OUT_W-1:0]  data_out,
    output logic              overflow,
    output logic              busy
);

    // No backpressure: a beat moves on valid && en; en = 0 freezes every stage.
    localparam int PW = 2 * DATA_W;
    localparam int MW = PW + 1;
    localparam logic [MW-1:0] LIM_NEG = MW'(1) << (OUT_W - 1);
    localparam logic [MW-1:0] LIM_POS = LIM_NEG - MW'(1);
    localparam logic [MW-1:0] RND_ADD = MW'(1) << (FRAC_W - 1);

    logic [DATA_W-1:0]    s0_a_d, s0_a_q, s0_b_d, s0_b_q;
    logic                 s0_sign_d, s0_sign_q, s0_rnd_d, s0_rnd_q;
    logic                 s0_sat_d, s0_sat_q, s0_vld_d, s0_vld_q;
    logic [DATA_W*PW-1:0] s1_pp_d, s1_pp_q;
    logic [2:0]           s1_side_d, s1_side_q;
    logic                 s1_vld_d, s1_vld_q;
    logic                 tree_vld, tree_busy;
    logic [2:0]           tree_side;
    logic [PW-1:0]        tree_sum;
    logic [MW-1:0]        sum_r, s3_mag_d, s3_mag_q;
    logic                 s3_sign_d, s3_sign_q, s3_sat_d, s3_sat_q;
    logic                 s3_ovf_d, s3_ovf_q, s3_vld_d, s3_vld_q;
    logic [OUT_W-1:0]     res, data_out_d, data_out_q;
    logic                 out_valid_d, out_valid_q, overflow_d, overflow_q;

    always_comb begin
        s0_a_d    = s0_a_q;
        s0_b_d    = s0_b_q;
        s0_sign_d = s0_sign_q;
        s0_rnd_d  = s0_rnd_q;
        s0_sat_d  = s0_sat_q;
        s0_vld_d  = s0_vld_q;
        s1_pp_d   = s1_pp_q;
        s1_side_d = s1_side_q;
        s1_vld_d  = s1_vld_q;
        if (en) begin
            s0_a_d    = a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
            s0_b_d    = b[DATA_W-1] ? (~b + DATA_W'(1)) : b;
            s0_sign_d = a[DATA_W-1] ^ b[DATA_W-1];
            s0_rnd_d  = round_mode;
            s0_sat_d  = sat_en;
            s0_vld_d  = in_valid;
            for (int i = 0; i < DATA_W; i++) begin
                s1_pp_d[i*PW +: PW] = s0_b_q[i] ? (PW'(s0_a_q) << i) : '0;
            end
            s1_side_d = {s0_sign_q, s0_rnd_q, s0_sat_q};
            s1_vld_d  = s0_vld_q;
        end
    end

    fx_mul_reduce_tree #(
        .N_TERMS (DATA_W),
        .TERM_W  (PW),
        .SIDE_W  (3)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (s1_vld_q),
        .in_side   (s1_side_q),
        .in_terms  (s1_pp_q),
        .out_valid (tree_vld),
        .out_side  (tree_side),
        .out_sum   (tree_sum),
        .busy      (tree_busy)
    );

    // Rescale: one extra bit keeps the rounding increment from wrapping.
    assign sum_r = MW'(tree_sum) + (tree_side[1] ? RND_ADD : '0);

    always_comb begin
        s3_mag_d  = s3_mag_q;
        s3_sign_d = s3_sign_q;
        s3_sat_d  = s3_sat_q;
        s3_ovf_d  = s3_ovf_q;
        s3_vld_d  = s3_vld_q;
        if (en) begin
            s3_mag_d  = sum_r >> FRAC_W;
            s3_sign_d = tree_side[2];
            s3_sat_d  = tree_side[0];
            s3_ovf_d  = tree_side[2] ? (s3_mag_d > LIM_NEG) : (s3_mag_d > LIM_POS);
            s3_vld_d  = tree_vld;
        end
    end

    always_comb begin
        res = s3_sign_q ? (~s3_mag_q[OUT_W-1:0] + OUT_W'(1)) : s3_mag_q[OUT_W-1:0];
        if (s3_mag_q == '0) res = '0;
        if (s3_ovf_q && s3_sat_q) res = s3_sign_q ? OUT_W'(LIM_NEG) : OUT_W'(LIM_POS);
    end

    // Bubbles clear out_valid but leave the last result on data_out.
    always_comb begin
        out_valid_d = en ? s3_vld_q : out_valid_q;
        data_out_d  = (en && s3_vld_q) ? res : data_out_q;
        overflow_d  = (en && s3_vld_q) ? s3_ovf_q : overflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s0_sign_q   <= 1'b0;
            s0_rnd_q    <= 1'b0;
            s0_sat_q    <= 1'b0;
            s0_vld_q    <= 1'b0;
            s1_pp_q     <= '0;
            s1_side_q   <= '0;
            s1_vld_q    <= 1'b0;
            s3_mag_q    <= '0;
            s3_sign_q   <= 1'b0;
            s3_sat_q    <= 1'b0;
            s3_ovf_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s0_a_q      <= s0_a_d;
            s0_b_q      <= s0_b_d;
            s0_sign_q   <= s0_sign_d;
            s0_rnd_q    <= s0_rnd_d;
            s0_sat_q    <= s0_sat_d;
            s0_vld_q    <= s0_vld_d;
            s1_pp_q     <= s1_pp_d;
            s1_side_q   <= s1_side_d;
            s1_vld_q    <= s1_vld_d;
            s3_mag_q    <= s3_mag_d;
            s3_sign_q   <= s3_sign_d;
            s3_sat_q    <= s3_sat_d;
            s3_ovf_q    <= s3_ovf_d;
            s3_vld_q    <= s3_vld_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;
    assign busy      = in_valid | s0_vld_q | s1_vld_q | tree_busy | s3_vld_q;

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Bench for fx_mul_pipe: a default instance (OUT_W=32) and an OUT_W=16 instance
// for overflow cases; results are collected by a monitor and checked against queues.
module tb_fx_mul_pipe;
    import fx_mul_pkg::*;

    localparam int LAT = lat_cycles(17);

    logic        clk, rst_n, en;
    logic        in_valid, round_mode, sat_en;
    logic [16:0] a, b;
    logic        out_valid, overflow, busy;
    logic [31:0] data_out;
    logic        in_valid16, round_mode16, sat_en16;
    logic [16:0] a16, b16;
    logic        out_valid16, overflow16, busy16;
    logic [15:0] data_out16;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [16:0] exp16_q[$];
    logic [16:0] obs16_q[$];

    int checks   = 0;
    int failures = 0;

    fx_mul_pipe u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .round_mode (round_mode),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    fx_mul_pipe #(.DATA_W(17), .FRAC_W(16), .OUT_W(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid16),
        .a          (a16),
        .b          (b16),
        .round_mode (round_mode16),
        .sat_en     (sat_en16),
        .out_valid  (out_valid16),
        .data_out   (data_out16),
        .overflow   (overflow16),
        .busy       (busy16)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: capture every accepted result beat away from the active edge.
    always @(negedge clk) begin
        if (en && out_valid)   obs_q.push_back({overflow, data_out});
        if (en && out_valid16) obs16_q.push_back({overflow16, data_out16});
    end

    // Reference: exact integer product, then rescale/round/saturate for OUT_W=32.
    function automatic logic [32:0] model(input logic [16:0] ma, input logic [16:0] mb,
                                          input logic rnd, input logic sat);
        longint sa, sb, p, mag, m, lim, r;
        logic   neg, ovf;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        p   = sa * sb;
        neg = ma[16] ^ mb[16];
        mag = (p < 0) ? -p : p;
        m   = rnd ? ((mag + 64'sd32768) >>> 16) : (mag >>> 16);
        lim = neg ? (64'sd1 <<< 31) : ((64'sd1 <<< 31) - 64'sd1);
        ovf = (m > lim);
        if (ovf && sat) r = neg ? -lim : lim;
        else            r = neg ? -m : m;
        return {ovf, r[31:0]};
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; a = '0; b = '0; round_mode = 1'b0; sat_en = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; round_mode16 = 1'b0; sat_en16 = 1'b0;
    endtask

    task automatic send(input logic [16:0] ta, input logic [16:0] tb,
                        input logic rnd, input logic sat, input logic [32:0] expv);
        @(posedge clk); #1;
        en = 1'b1; in_valid = 1'b1; a = ta; b = tb; round_mode = rnd; sat_en = sat;
        exp_q.push_back(expv);
    endtask

    task automatic send16(input logic [16:0] ta, input logic [16:0] tb,
                          input logic sat, input logic [16:0] expv);
        @(posedge clk); #1;
        en = 1'b1; in_valid16 = 1'b1; a16 = ta; b16 = tb; round_mode16 = 1'b0; sat_en16 = sat;
        exp16_q.push_back(expv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({out_valid16, data_out16, busy16} !== 18'h0) begin failures++; $display("FAIL reset_dut16 got=%h exp=0", {out_valid16, data_out16, busy16}); end
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_latency();
        int  lat;
        logic busy_prev;
        obs_q.delete();
        @(posedge clk); #1;
        en = 1'b1; in_valid = 1'b1; a = 17'h0C000; b = 17'h18000; round_mode = 1'b0; sat_en = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_on_input got=%b exp=1", busy); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy_prev = busy;
        while (!out_valid && lat < 40) begin
            busy_prev = busy;
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (data_out !== 32'hFFFFA000) begin failures++; $display("FAIL mul_0p75_m0p5 got=%h exp=FFFFA000", data_out); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mul_ovf got=%b exp=0", overflow); end
        checks++; if (busy_prev !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL busy_fall got=%b%b exp=10", busy_prev, busy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b exp=0", out_valid); end
        checks++; if (data_out !== 32'hFFFFA000) begin failures++; $display("FAIL bubble_hold got=%h exp=FFFFA000", data_out); end
        obs_q.delete();
    endtask

    task automatic test_vectors();
        logic [32:0] got, expv;
        send(17'h00001, 17'h08000, RND_TRUNC,     1'b0, 33'h0_00000000);
        send(17'h00001, 17'h08000, RND_HALF_AWAY, 1'b0, 33'h0_00000001);
        send(17'h1FFFF, 17'h08000, RND_HALF_AWAY, 1'b0, 33'h0_FFFFFFFF);
        send(17'h10000, 17'h10000, RND_TRUNC,     1'b0, 33'h0_00010000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 60 && obs_q.size() < 4; i++) @(posedge clk);
        #1;
        checks++; if (obs_q.size() !== 4) begin failures++; $display("FAIL vec_count got=%0d exp=4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); expv = exp_q.pop_front();
                checks++;
                if (got !== expv) begin failures++; $display("FAIL vec%0d got=%h exp=%h", i, got, expv); end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        logic [16:0] got, expv;
        send16(17'h0FFFF, 17'h0FFFF, 1'b0, 17'h1_FFFE);
        send16(17'h0FFFF, 17'h0FFFF, 1'b1, 17'h1_7FFF);
        send16(17'h10001, 17'h0FFFF, 1'b1, 17'h1_8000);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        for (int i = 0; i < 60 && obs16_q.size() < 3; i++) @(posedge clk);
        #1;
        checks++; if (obs16_q.size() !== 3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", obs16_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (obs16_q.size() > 0 && exp16_q.size() > 0) begin
                got = obs16_q.pop_front(); expv = exp16_q.pop_front();
                checks++;
                if (got !== expv) begin failures++; $display("FAIL ovf%0d got=%h exp=%h", i, got, expv); end
            end
        end
        exp16_q.delete(); obs16_q.delete();
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int guard = 0;
        logic [32:0] got, expv;
        obs_q.delete(); exp_q.delete();
        while (sent < 20 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
            en = ($urandom_range(0, 3) != 0);
            a = 17'($urandom_range(0, 131071));
            b = 17'($urandom_range(0, 131071));
            round_mode = 1'($urandom_range(0, 1));
            sat_en = 1'($urandom_range(0, 1));
            if (en) begin
                in_valid = 1'b1;
                exp_q.push_back(model(a, b, round_mode, sat_en));
                sent++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            en = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        en = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++; if (obs_q.size() !== 20) begin failures++; $display("FAIL stream_count got=%0d exp=20", obs_q.size()); end
        for (int i = 0; i < 20; i++) begin
            if (obs_q.size() > 0 && exp_q.size() > 0) begin
                got = obs_q.pop_front(); expv = exp_q.pop_front();
                checks++;
                if (got !== expv) begin failures++; $display("FAIL stream%0d got=%h exp=%h", i, got, expv); end
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy got=%b exp=0", busy); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            en = 1'b1; in_valid = 1'b1;
            a = 17'($urandom_range(1, 65535)); b = 17'($urandom_range(1, 65535));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL mid_data_out got=%h exp=0", data_out); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 6) @(posedge clk);
        #1;
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL mid_stale_valid got=%0d exp=0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
